// File: rtl/risc_v_mike_gpio_ctrl_if.sv
// risc_v_mike_gpio_ctrl_if: request/ready load-store port between the core and the GPIO block
interface risc_v_mike_gpio_ctrl_if;
   logic        bus_req;
   logic        bus_we;
   logic [2:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ready;
   modport master (output bus_req, bus_we, bus_addr, bus_wdata, input bus_rdata, bus_ready);
   modport slave (input bus_req, bus_we, bus_addr, bus_wdata, output bus_rdata, bus_ready);
endinterface

// File: rtl/risc_v_mike_gpio_ctrl.sv
// risc_v_mike_gpio_ctrl: memory-mapped GPIO with input sync, edge detect and W1C interrupt pending bits
module risc_v_mike_gpio_ctrl #(
   parameter int GPIO_BYTE   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   risc_v_mike_gpio_ctrl_if.slave   bus,
   input  logic [GPIO_BYTE-1:0]     gpio_port_in,
   output logic [GPIO_BYTE-1:0]     gpio_port_out,
   output logic                     gpio_irq
);
   logic [SYNC_STAGES-1:0][GPIO_BYTE-1:0] sync_q;
   logic [GPIO_BYTE-1:0] sync_in, prev_in, out_q, rise_en, fall_en, pend;
   logic [GPIO_BYTE-1:0] out_d, rise_d, fall_d, pend_d, wd, w1c;
   logic [31:0] rmux, rd_q;
   logic        wr, acc_q;
   assign sync_in       = sync_q[SYNC_STAGES-1];
   assign wr            = bus.bus_req & bus.bus_we;
   assign wd            = bus.bus_wdata[GPIO_BYTE-1:0];
   assign gpio_port_out = out_q;
   always_comb begin
      out_d  = !wr                  ? out_q :
               bus.bus_addr == 3'd0 ? wd :
               bus.bus_addr == 3'd5 ? out_q | wd :
               bus.bus_addr == 3'd6 ? out_q & ~wd : out_q;
      rise_d = (wr && bus.bus_addr == 3'd2) ? wd : rise_en;
      fall_d = (wr && bus.bus_addr == 3'd3) ? wd : fall_en;
      w1c    = (wr && bus.bus_addr == 3'd4) ? wd : '0;
      // a fresh edge on a bit being cleared keeps that bit set
      pend_d = (pend & ~w1c) | (sync_in & ~prev_in & rise_en) | (~sync_in & prev_in & fall_en);
      rmux   = '0;
      rmux[GPIO_BYTE-1:0] = bus.bus_addr == 3'd0 ? out_q :
                            bus.bus_addr == 3'd1 ? sync_in :
                            bus.bus_addr == 3'd2 ? rise_en :
                            bus.bus_addr == 3'd3 ? fall_en :
                            bus.bus_addr == 3'd4 ? pend : '0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q        <= '0;
         prev_in       <= '0;
         out_q         <= '0;
         rise_en       <= '0;
         fall_en       <= '0;
         pend          <= '0;
         gpio_irq      <= 1'b0;
         acc_q         <= 1'b0;
         rd_q          <= '0;
         bus.bus_ready <= 1'b0;
         bus.bus_rdata <= '0;
      end else begin
         sync_q        <= {sync_q[SYNC_STAGES-2:0], gpio_port_in};
         prev_in       <= sync_in;
         out_q         <= out_d;
         rise_en       <= rise_d;
         fall_en       <= fall_d;
         pend          <= pend_d;
         gpio_irq      <= |pend_d;
         acc_q         <= bus.bus_req;
         rd_q          <= (bus.bus_req && !bus.bus_we) ? rmux : '0;
         bus.bus_ready <= acc_q;
         bus.bus_rdata <= acc_q ? rd_q : '0;
      end
   end
endmodule

// File: tb/tb_risc_v_mike_gpio_ctrl.sv
// tb_risc_v_mike_gpio_ctrl: directed and random checks of the GPIO block against a behavioural model
module tb_risc_v_mike_gpio_ctrl;
   localparam int W = 8;
   localparam int S = 2;
   logic clk = 1'b0;
   logic rst;
   logic [W-1:0] pin_in, pin_out;
   logic irq;
   int checks = 0;
   int errors = 0;
   logic [W-1:0] m_out, m_rise, m_fall, m_pend;
   logic [W-1:0] hist[$];
   logic m_irq, st_v, e_ready;
   logic [31:0] st_d, e_rdata;
   risc_v_mike_gpio_ctrl_if bif ();
   risc_v_mike_gpio_ctrl #(.GPIO_BYTE(W), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst(rst), .bus(bif.slave),
      .gpio_port_in(pin_in), .gpio_port_out(pin_out), .gpio_irq(irq)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      m_out = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_irq = 1'b0;
      st_v = 1'b0; st_d = '0; e_ready = 1'b0; e_rdata = '0;
      hist = {};
      repeat (S + 1) hist.push_front('0);
   endtask
   function automatic logic [31:0] rd_model(input logic [2:0] a, input logic [W-1:0] sin);
      logic [31:0] v;
      v = '0;
      case (a)
         3'd0: v[W-1:0] = m_out;
         3'd1: v[W-1:0] = sin;
         3'd2: v[W-1:0] = m_rise;
         3'd3: v[W-1:0] = m_fall;
         3'd4: v[W-1:0] = m_pend;
         default: v = '0;
      endcase
      return v;
   endfunction
   // advance model and DUT by one clock, then compare all outputs
   task automatic step();
      logic [W-1:0] sin, prev, wd, w1c;
      logic wr;
      sin  = hist[S-1];
      prev = hist[S];
      wr   = bif.bus_req & bif.bus_we;
      wd   = bif.bus_wdata[W-1:0];
      w1c  = (wr && bif.bus_addr == 3'd4) ? wd : '0;
      e_ready = st_v;
      e_rdata = st_v ? st_d : '0;
      st_v = bif.bus_req;
      st_d = (bif.bus_req && !bif.bus_we) ? rd_model(bif.bus_addr, sin) : '0;
      m_pend = (m_pend & ~w1c) | (sin & ~prev & m_rise) | (~sin & prev & m_fall);
      m_irq  = |m_pend;
      if (wr) begin
         case (bif.bus_addr)
            3'd0: m_out = wd;
            3'd2: m_rise = wd;
            3'd3: m_fall = wd;
            3'd5: m_out = m_out | wd;
            3'd6: m_out = m_out & ~wd;
            default: ;
         endcase
      end
      hist.push_front(pin_in);
      void'(hist.pop_back());
      @(posedge clk);
      #1;
      chk("m_pins", 32'(pin_out), 32'(m_out));
      chk("m_ready", 32'(bif.bus_ready), 32'(e_ready));
      chk("m_rdata", bif.bus_rdata, e_rdata);
      chk("m_irq", 32'(irq), 32'(m_irq));
   endtask
   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
      bif.bus_req = 1'b1; bif.bus_we = 1'b1; bif.bus_addr = a; bif.bus_wdata = d;
      step();
      bif.bus_req = 1'b0; bif.bus_we = 1'b0;
   endtask
   task automatic read_expect(input logic [2:0] a, input logic [31:0] exp, input string tag);
      bif.bus_req = 1'b1; bif.bus_we = 1'b0; bif.bus_addr = a;
      step();
      bif.bus_req = 1'b0;
      step();
      chk(tag, bif.bus_rdata, exp);
   endtask
   initial begin
      rst = 1'b1;
      pin_in = '0;
      bif.bus_req = 1'b0; bif.bus_we = 1'b0; bif.bus_addr = '0; bif.bus_wdata = '0;
      model_reset();
      repeat (3) begin
         pin_in = W'($urandom);
         bif.bus_req = 1'b1; bif.bus_we = 1'($urandom); bif.bus_addr = 3'($urandom); bif.bus_wdata = $urandom;
         @(posedge clk);
         #1;
         chk("rst_pins", 32'(pin_out), 0);
         chk("rst_ready", 32'(bif.bus_ready), 0);
         chk("rst_irq", 32'(irq), 0);
      end
      bif.bus_req = 1'b0; bif.bus_we = 1'b0; pin_in = '0;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) read_expect(3'(i), 0, "rst_read");
      bus_wr(3'd0, 32'hA5);
      chk("out_write", 32'(pin_out), 32'hA5);
      bus_wr(3'd5, 32'h0F);
      chk("out_set", 32'(pin_out), 32'hAF);
      bus_wr(3'd6, 32'h81);
      chk("out_clr", 32'(pin_out), 32'h2E);
      read_expect(3'd0, 32'h2E, "read_out");
      read_expect(3'd5, 0, "read_set");
      read_expect(3'd6, 0, "read_clr");
      pin_in = 8'h3C;
      read_expect(3'd1, 0, "in_early");
      read_expect(3'd1, 32'h3C, "in_sync");
      pin_in = 8'h02;
      repeat (4) step();
      bus_wr(3'd2, 32'h01);
      bus_wr(3'd3, 32'h02);
      pin_in = 8'h01;
      repeat (2) step();
      chk("edge_irq_early", 32'(irq), 0);
      step();
      chk("edge_irq", 32'(irq), 1);
      read_expect(3'd4, 32'h03, "edge_pend");
      pin_in = 8'h05;
      repeat (4) step();
      read_expect(3'd4, 32'h03, "pin2_ignored");
      bus_wr(3'd4, 32'h01);
      read_expect(3'd4, 32'h02, "w1c_bit0");
      bus_wr(3'd4, 32'h02);
      chk("w1c_irq", 32'(irq), 0);
      pin_in = 8'h04;
      repeat (4) step();
      pin_in = 8'h05;
      repeat (2) step();
      bus_wr(3'd4, 32'h01);
      chk("collide_irq", 32'(irq), 1);
      read_expect(3'd4, 32'h01, "collide_pend");
      bif.bus_req = 1'b1; bif.bus_we = 1'b1; bif.bus_addr = 3'd0; bif.bus_wdata = 32'h5A;
      step();
      bif.bus_we = 1'b0;
      step();
      chk("b2b_ready0", 32'(bif.bus_ready), 1);
      bif.bus_addr = 3'd1;
      step();
      chk("b2b_ready1", 32'(bif.bus_ready), 1);
      chk("b2b_out", bif.bus_rdata, 32'h5A);
      bif.bus_addr = 3'd7;
      step();
      chk("b2b_ready2", 32'(bif.bus_ready), 1);
      bif.bus_req = 1'b0;
      step();
      chk("b2b_ready3", 32'(bif.bus_ready), 1);
      chk("b2b_res", bif.bus_rdata, 0);
      step();
      chk("b2b_idle", 32'(bif.bus_ready), 0);
      bif.bus_req = 1'b1; bif.bus_we = 1'b0; bif.bus_addr = 3'd0;
      step();
      bif.bus_req = 1'b0;
      #2 rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      chk("abort_ready", 32'(bif.bus_ready), 0);
      chk("abort_pins", 32'(pin_out), 0);
      chk("abort_irq", 32'(irq), 0);
      pin_in = '0;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) read_expect(3'(i), 0, "abort_read");
      repeat (400) begin
         bif.bus_req = 1'($urandom);
         bif.bus_we = 1'($urandom);
         bif.bus_addr = 3'($urandom);
         bif.bus_wdata = $urandom;
         if ($urandom_range(0, 3) == 0) pin_in = W'($urandom);
         step();
      end
      bif.bus_req = 1'b0;
      repeat (2) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/risc_v_mike_gpio_ctrl.md
Name: risc_v_mike_gpio_ctrl

Overview:
- Memory-mapped GPIO peripheral on the core's data-bus side; drives `gpio_port_out` and samples `gpio_port_in` at the top-level pins.
- The core reaches it through a simple request/ready load-store port.
- It synchronises the input pins, detects configurable edges and raises a level interrupt with write-1-to-clear pending bits.

Parameters:
- GPIO_BYTE, 8, number of GPIO pins (1..32); register fields use bits [GPIO_BYTE-1:0], upper bits read 0.
- SYNC_STAGES, 2, flip-flop stages on gpio_port_in (legal 2..3).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- bus_req  in  1  one-cycle access request from the core.
- bus_we  in  1  1 = write, 0 = read; valid with bus_req.
- bus_addr  in  3  word index into the register map.
- bus_wdata  in  32  write data; valid with bus_req & bus_we.
- bus_rdata  out  32  read data; valid when bus_ready=1, 0 otherwise.
- bus_ready  out  1  one-cycle completion pulse.
- gpio_port_in  in  GPIO_BYTE  asynchronous external pins.
- gpio_port_out  out  GPIO_BYTE  registered output pins.
- gpio_irq  out  1  level interrupt = |(PEND).

Behaviour:
- Register map (word index):
  - 0 OUT: RW.
  - 1 IN: RO, synchronised pin value.
  - 2 RISE_EN: RW.
  - 3 FALL_EN: RW.
  - 4 PEND: RW1C.
  - 5 SET: WO, OUT |= wdata.
  - 6 CLR: WO, OUT &= ~wdata.
  - 7 reserved: reads 0, writes ignored.
  - WO registers read 0.
- Reset (async, rst=1): OUT, RISE_EN, FALL_EN, PEND, sync chain, prev-sample = 0; bus_ready=0, bus_rdata=0, gpio_irq=0.
  - Reset mid-access cancels it; no ready pulse is issued for that access.
- Bus handshake:
  - bus_req sampled at edge N → bus_ready=1 for exactly one cycle after edge N+1.
  - bus_rdata is registered with the same timing.
  - Write side effects are visible in registers after edge N.
- Back-to-back: a new bus_req may be asserted every cycle; each gets its own ready pulse one cycle later. Pipeline depth 1, no stall.
- Reads return the register value before any same-cycle update; a read of PEND in the same cycle as a new edge returns the old value.
- SET/CLR vs OUT: only one access per cycle, so no conflict. gpio_port_out = OUT directly, so a write is reflected at the pins 1 cycle after the req edge.
- Input path:
  - SYNC_STAGES flops produce sync_in.
  - prev_in <= sync_in every cycle.
  - IN reads sync_in.
  - A pin change is visible in IN SYNC_STAGES cycles later.
- Edge detect:
  - rise = sync_in & ~prev_in & RISE_EN.
  - fall = ~sync_in & prev_in & FALL_EN.
  - PEND <= (PEND & ~w1c) | rise | fall.
  - A pin edge sets PEND SYNC_STAGES+1 cycles after it.
  - Simultaneous W1C of a bit and a new edge on that bit: set wins, bit stays 1.
- gpio_irq is registered from next-state PEND, so it follows PEND in the same cycle.
- Enabling RISE_EN while a pin is already high does not set PEND; only transitions count.
- Writes to fields above GPIO_BYTE are ignored.

Test Plan:
- Reset: hold rst=1, toggle pins and bus → gpio_port_out=0, bus_ready=0, gpio_irq=0. Release, then read index 0..4 → all return 0.
- Output: write OUT=0xA5, then SET 0x0F, then CLR 0x81 → pins 0xA5, then 0xAF, then 0x2E, each 1 cycle after the req edge. Read OUT=0x2E. Reads of SET/CLR return 0.
- Input sync: drive gpio_port_in=0x3C mid-cycle → IN reads 0x00 until 2 edges have passed, then 0x3C. bus_ready always pulses exactly 1 cycle after req.
- Edges:
  - Set RISE_EN=0x01, FALL_EN=0x02. Pin0 0→1 and pin1 1→0 → PEND=0x03 3 cycles later, gpio_irq=1.
  - Pin2 toggles → no PEND change.
  - W1C 0x01 → PEND=0x02.
  - W1C 0x02 → gpio_irq=0.
- Collision: pin0 rising edge reaches detection in the same cycle as W1C 0x01 → PEND[0] stays 1 and gpio_irq stays 1.
- Back-to-back and reset abort:
  - req every cycle for 4 cycles (write OUT, read OUT, read IN, read 7) → 4 consecutive ready pulses; the read of OUT returns the value just written; index 7 reads 0.
  - Assert rst in the cycle after a req → no ready pulse, and all registers are 0.
